// File: rtl/common.sv
// Shared loader definitions: FSM state type and the end-of-program marker
// that the fetch stage also compares against.
package common;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    MARK0,
    MARK1,
    RUN,
    ERROR
  } loader_state_type;

  // 32-bit end-of-program instruction appended after every loaded image.
  localparam logic [31:0] END_MARKER = 32'h00001111;

endpackage

// File: rtl/instr_mem.sv
// Halfword-organised instruction RAM: one synchronous write port and two
// combinational read ports returning hw[idx] and hw[idx+1] (wrapping).
module instr_mem #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] idx,
  output logic [15:0]   rdata_lo,
  output logic [15:0]   rdata_hi
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] idx_next;

  // DEPTH is a power of two, so the AW-bit increment wraps the top halfword to 0.
  assign idx_next = idx + 1'b1;

  // Single write port, written at the edge that completes a halfword.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_lo = mem[idx];
  assign rdata_hi = mem[idx_next];

endmodule

// File: rtl/instr_loader_mem.sv
// Instruction memory with a serial program loader. A little-endian 32-bit
// length header is followed by the payload bytes, which are packed into
// halfwords; the end marker is appended and run_flag raised for fetch.
module instr_loader_mem
  import common::*;
#(
  parameter int MEM_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        clear_error,
  input  logic        run_done,
  input  logic [31:0] address,
  output logic [31:0] data,
  output logic        run_flag,
  output logic        loading,
  output logic        load_error,
  output logic [31:0] load_bytes
);

  localparam int          DEPTH     = 2 * MEM_WORDS;
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [32:0] CAP_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [31:0] TIMEOUT_U = 32'(TIMEOUT_CYCLES);

  loader_state_type state_reg, state_next;
  logic [31:0]      len_reg, len_next;
  logic [1:0]       len_cnt_reg, len_cnt_next;
  logic [7:0]       low_reg, low_next;
  logic             hi_phase_reg, hi_phase_next;
  logic [AW-1:0]    wp_reg, wp_next;
  logic [31:0]      load_bytes_reg, load_bytes_next;
  logic [31:0]      gap_reg, gap_next;
  logic             run_flag_reg, loading_reg, load_error_reg;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [15:0]      wdata;
  logic [AW-1:0]    rd_idx;
  logic [15:0]      rd_lo, rd_hi;

  logic [31:0]      len_full;
  logic             len_bad;
  logic             addr_unused;

  // The header is complete when the 4th byte arrives; judge it before it is stored.
  assign len_full = {rx_byte, len_reg[23:0]};
  assign len_bad  = len_full[0] || (({1'b0, len_full} + 33'd4) > CAP_BYTES);

  // Next-state, byte assembly, RAM write port and gap counter.
  always_comb begin
    state_next      = state_reg;
    len_next        = len_reg;
    len_cnt_next    = len_cnt_reg;
    low_next        = low_reg;
    hi_phase_next   = hi_phase_reg;
    wp_next         = wp_reg;
    load_bytes_next = load_bytes_reg;
    gap_next        = 32'd0;
    we              = 1'b0;
    waddr           = wp_reg;
    wdata           = 16'h0000;

    case (state_reg)
      IDLE: begin
        if (rx_valid) begin
          len_next        = {24'd0, rx_byte};
          len_cnt_next    = 2'd1;
          wp_next         = '0;
          load_bytes_next = 32'd0;
          hi_phase_next   = 1'b0;
          state_next      = LEN;
        end
      end
      LEN: begin
        if (rx_valid) begin
          len_cnt_next = len_cnt_reg + 2'd1;
          case (len_cnt_reg)
            2'd1:    len_next[15:8]  = rx_byte;
            2'd2:    len_next[23:16] = rx_byte;
            default: begin
              len_next = len_full;
              if (len_bad) begin
                state_next = ERROR;
              end else if (len_full == 32'd0) begin
                state_next = MARK0;
              end else begin
                state_next = DATA;
              end
            end
          endcase
        end
      end
      DATA: begin
        if (rx_valid) begin
          if (!hi_phase_reg) begin
            low_next      = rx_byte;
            hi_phase_next = 1'b1;
          end else begin
            we              = 1'b1;
            wdata           = {rx_byte, low_reg};
            wp_next         = wp_reg + 1'b1;
            load_bytes_next = load_bytes_reg + 32'd2;
            hi_phase_next   = 1'b0;
            if (load_bytes_reg + 32'd2 == len_reg) begin
              state_next = MARK0;
            end
          end
        end
      end
      MARK0: begin
        we         = 1'b1;
        wdata      = END_MARKER[15:0];
        wp_next    = wp_reg + 1'b1;
        state_next = MARK1;
      end
      MARK1: begin
        we         = 1'b1;
        wdata      = END_MARKER[31:16];
        state_next = RUN;
      end
      RUN: begin
        if (run_done) begin
          state_next = IDLE;
        end
      end
      ERROR: begin
        if (clear_error) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // An arriving byte always beats the timeout on the same edge.
    if (state_reg == LEN || state_reg == DATA) begin
      if (!rx_valid) begin
        gap_next = gap_reg + 32'd1;
        if (TIMEOUT_U != 32'd0 && gap_next == TIMEOUT_U) begin
          state_next = ERROR;
        end
      end
    end
  end

  // State and datapath registers; status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      len_reg        <= 32'd0;
      len_cnt_reg    <= 2'd0;
      low_reg        <= 8'd0;
      hi_phase_reg   <= 1'b0;
      wp_reg         <= '0;
      load_bytes_reg <= 32'd0;
      gap_reg        <= 32'd0;
      run_flag_reg   <= 1'b0;
      loading_reg    <= 1'b0;
      load_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      len_reg        <= len_next;
      len_cnt_reg    <= len_cnt_next;
      low_reg        <= low_next;
      hi_phase_reg   <= hi_phase_next;
      wp_reg         <= wp_next;
      load_bytes_reg <= load_bytes_next;
      gap_reg        <= gap_next;
      run_flag_reg   <= (state_next == RUN);
      loading_reg    <= (state_next == LEN) || (state_next == DATA) ||
                        (state_next == MARK0) || (state_next == MARK1);
      load_error_reg <= (state_next == ERROR);
    end
  end

  // Byte address bit 0 and the bits above the RAM depth do not select anything.
  assign rd_idx      = address[AW:1];
  assign addr_unused = ^{address[31:AW+1], address[0]};

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .idx      (rd_idx),
    .rdata_lo (rd_lo),
    .rdata_hi (rd_hi)
  );

  assign data       = {rd_hi, rd_lo};
  assign run_flag   = run_flag_reg;
  assign loading    = loading_reg;
  assign load_error = load_error_reg;
  assign load_bytes = load_bytes_reg;

endmodule

// File: tb/tb_instr_loader_mem.sv
// Bench for instr_loader_mem: a byte-count based model of the loader and a
// halfword array mirror of the RAM, checked every cycle, plus directed
// literal expectations for the documented scenarios.
module tb_instr_loader_mem;

  localparam int MW    = 64;
  localparam int TO    = 16;
  localparam int DEPTH = 2 * MW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = 8'd0;
  logic        rx_valid = 1'b0;
  logic        clear_error = 1'b0;
  logic        run_done = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] data;
  logic        run_flag;
  logic        loading;
  logic        load_error;
  logic [31:0] load_bytes;

  int tests = 0;
  int fails = 0;

  instr_loader_mem #(
    .MEM_WORDS      (MW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .clear_error (clear_error),
    .run_done    (run_done),
    .address     (address),
    .data        (data),
    .run_flag    (run_flag),
    .loading     (loading),
    .load_error  (load_error),
    .load_bytes  (load_bytes)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_MARK = 2, M_RUN = 3, M_ERR = 4;
  int          m_mode = M_IDLE;
  int          m_n = 0;       // bytes accepted in this image, header included
  int          m_gap = 0;
  int          m_mark = 0;
  longint      m_len = 0;
  logic [31:0] m_lb = 32'd0;
  logic [7:0]  m_low = 8'd0;
  logic [15:0] m_hw [DEPTH];
  bit          m_known [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_write(input int i, input logic [15:0] v);
    m_hw[i % DEPTH]    = v;
    m_known[i % DEPTH] = 1'b1;
  endtask

  task automatic model_step();
    int k;
    if (reset) begin
      m_mode = M_IDLE;
      m_lb   = 32'd0;
      m_gap  = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (rx_valid) begin
        m_len  = longint'(rx_byte);
        m_n    = 1;
        m_lb   = 32'd0;
        m_gap  = 0;
        m_mode = M_LOAD;
      end
      M_LOAD: begin
        if (rx_valid) begin
          m_gap = 0;
          if (m_n < 4) begin
            m_len = m_len | (longint'(rx_byte) << (8 * m_n));
            m_n++;
            if (m_n == 4) begin
              if ((m_len % 2) != 0 || m_len + 4 > 4 * MW) m_mode = M_ERR;
              else if (m_len == 0) begin m_mode = M_MARK; m_mark = 0; end
            end
          end else begin
            k = m_n - 4;
            if (k % 2 == 0) m_low = rx_byte;
            else begin
              model_write(k / 2, {rx_byte, m_low});
              m_lb = 32'(k + 1);
            end
            m_n++;
            if (longint'(k + 1) == m_len) begin m_mode = M_MARK; m_mark = 0; end
          end
        end else begin
          m_gap++;
          if (m_gap == TO) m_mode = M_ERR;
        end
      end
      M_MARK: begin
        if (m_mark == 0) begin
          model_write(int'(m_len / 2), 16'h1111);
          m_mark = 1;
        end else begin
          model_write(int'(m_len / 2) + 1, 16'h0000);
          m_mode = M_RUN;
        end
      end
      M_RUN: if (run_done) m_mode = M_IDLE;
      M_ERR: if (clear_error) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic compare_cycle();
    int i, j;
    check("run_flag", 32'(run_flag), 32'(m_mode == M_RUN));
    check("loading", 32'(loading), 32'(m_mode == M_LOAD || m_mode == M_MARK));
    check("load_error", 32'(load_error), 32'(m_mode == M_ERR));
    check("load_bytes", load_bytes, m_lb);
    i = int'((address >> 1) % DEPTH);
    j = (i + 1) % DEPTH;
    if (m_known[i] && m_known[j]) check("data", data, {m_hw[j], m_hw[i]});
  endtask

  // Model advances on each active edge and is compared on the opposite edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_cycle();
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    idle(gap);
    rx_byte  = b;
    rx_valid = 1'b1;
    address  = $urandom;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic send_header(input longint len, input int maxgap);
    for (int b = 0; b < 4; b++) send(8'(len >> (8 * b)), $urandom_range(0, maxgap));
  endtask

  task automatic read_check(input string nm, input logic [31:0] a, input logic [31:0] e);
    @(negedge clk); #1;
    address = a;
    #1;
    check(nm, data, e);
  endtask

  task automatic pulse_done(input bit with_byte);
    run_done = 1'b1;
    rx_valid = with_byte;
    rx_byte  = 8'h33;
    @(posedge clk); #1;
    run_done = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_error = 1'b1;
    @(posedge clk); #1;
    clear_error = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  logic [7:0] t1 [12] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05,
                          8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

  initial begin
    int len;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_run_flag", 32'(run_flag), 32'd0);
    check("reset_load_bytes", load_bytes, 32'd0);

    // Basic load and marker latency
    for (int k = 0; k < 12; k++) send(t1[k], 0);
    @(negedge clk); check("t1_run_E", 32'(run_flag), 32'd0);
    @(negedge clk); check("t1_run_E1", 32'(run_flag), 32'd0);
    @(negedge clk); check("t1_run_E2", 32'(run_flag), 32'd1);
    check("t1_load_bytes", load_bytes, 32'd8);
    read_check("t1_a0", 32'd0, 32'h00100513);
    read_check("t1_a4", 32'd4, 32'h00200593);
    read_check("t1_a5", 32'd5, 32'h00200593);
    read_check("t1_a8", 32'd8, 32'h00001111);
    $display("[TB] image len=8 loaded");

    // run_done with a simultaneous byte: byte dropped
    pulse_done(1'b1);
    @(negedge clk);
    check("rd_run_flag", 32'(run_flag), 32'd0);
    check("rd_loading", 32'(loading), 32'd0);

    // Halfword-aligned marker
    send_header(2, 0);
    send(8'h01, 0);
    send(8'h45, 0);
    idle(3);
    read_check("t2_a2", 32'd2, 32'h00001111);
    read_check("t2_a0", 32'd0, 32'h11114501);
    $display("[TB] image len=2 loaded");
    pulse_done(1'b0);

    // Odd length
    send_header(3, 0);
    @(negedge clk); check("t3_err_odd", 32'(load_error), 32'd1);
    send(8'h55, 0); send(8'h66, 1);
    @(negedge clk);
    check("t3_err_hold", 32'(load_error), 32'd1);
    check("t3_not_loading", 32'(loading), 32'd0);
    pulse_clear();
    @(negedge clk); check("t3_cleared", 32'(load_error), 32'd0);
    $display("[TB] len=3 rejected");

    // Length that leaves no room for the marker
    send_header(4 * MW, 0);
    @(negedge clk); check("t3_err_big", 32'(load_error), 32'd1);
    pulse_clear();
    $display("[TB] len=%0d rejected", 4 * MW);

    // Timeout: a byte at gap 15 keeps loading, then exactly 16 idle cycles errors
    send_header(10, 0);
    send(8'hAA, 0);
    idle(14);
    send(8'hBB, 0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("t4_still_loading", 32'(loading), 32'd1);
    check("t4_no_err_yet", 32'(load_error), 32'd0);
    check("t4_load_bytes", load_bytes, 32'd2);
    @(posedge clk); @(negedge clk);
    check("t4_timeout_err", 32'(load_error), 32'd1);
    pulse_clear();
    $display("[TB] timeout observed");

    // Reset mid-DATA, then a fresh load
    send_header(8, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_run_flag", 32'(run_flag), 32'd0);
    check("t6_loading", 32'(loading), 32'd0);
    check("t6_load_error", 32'(load_error), 32'd0);
    check("t6_load_bytes", load_bytes, 32'd0);
    send_header(4, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    idle(3);
    read_check("t6_a0", 32'd0, 32'h44332211);
    read_check("t6_a4", 32'd4, 32'h00001111);
    $display("[TB] image len=4 loaded after reset");
    pulse_done(1'b0);

    // Largest image: marker fills the top two halfwords, reads wrap to hw[0]
    send_header(4 * MW - 4, 0);
    for (int k = 0; k < 4 * MW - 4; k++) send(8'(k) ^ 8'h5A, 0);
    idle(3);
    read_check("max_a252", 32'd252, 32'h00001111);
    read_check("max_wrap", 32'd254, 32'h5B5A0000);
    check("max_run_flag", 32'(run_flag), 32'd1);
    $display("[TB] image len=%0d loaded", 4 * MW - 4);
    pulse_done(1'b1);

    // Random images with random gaps, reads and ignored bytes while running
    for (int r = 0; r < 12; r++) begin
      len = 2 * int'($urandom_range(0, 30));
      send_header(longint'(len), 4);
      for (int k = 0; k < len; k++) send(8'($urandom), $urandom_range(0, 4));
      idle(3);
      repeat (10) begin
        @(posedge clk); #1;
        address  = $urandom;
        rx_valid = 1'($urandom_range(0, 1));
        rx_byte  = 8'($urandom);
      end
      rx_valid = 1'b0;
      $display("[TB] random image %0d len=%0d loaded", r, len);
      pulse_done(1'($urandom_range(0, 1)));
      idle(2);
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_loader_mem.md
# instr_loader_mem

Instruction memory with a serial program loader, sitting directly upstream of the fetch stage. It accepts a byte stream from the UART receiver, writes a length-prefixed program image into a halfword-organised RAM, appends the end-of-program marker, and raises `run_flag`. While running, it serves the fetch stage's `address` with a combinational 32-bit instruction window.

## Interface
Parameters:
- `MEM_WORDS`, 1024: capacity in 32-bit words. RAM holds 2*MEM_WORDS halfwords. Must be a power of two.
- `TIMEOUT_CYCLES`, 100000: maximum idle cycles between bytes while loading. 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `rx_byte`  in  8  received byte
- `rx_valid`  in  1  single-cycle strobe; `rx_byte` is valid this cycle
- `clear_error`  in  1  leaves ERROR
- `run_done`  in  1  end-of-program indication from the fetch stage
- `address`  in  32  fetch byte address; bit 0 is ignored
- `data`  out  32  `{hw[idx+1], hw[idx]}`, where `idx = address[..:1] mod (2*MEM_WORDS)`; combinational
- `run_flag`  out  1  program loaded; fetch may run
- `loading`  out  1  high in LEN, DATA, MARK0 and MARK1
- `load_error`  out  1  high in ERROR
- `load_bytes`  out  32  payload bytes written so far

## Operation
States: IDLE, LEN, DATA, MARK0, MARK1, RUN, ERROR. A byte is accepted on any edge where `rx_valid` is high and the state is IDLE, LEN or DATA. In all other states bytes are dropped.

- **IDLE**
  - An accepted byte becomes `len[7:0]`. Go to LEN.
  - Clear `load_bytes` and the write pointer `wp` (halfword index) to 0.
- **LEN**
  - Collect `len[15:8]`, `len[23:16]` and `len[31:24]` (little-endian).
  - On the 4th byte, check the length:
    - `len` odd, or `len + 4 > 4*MEM_WORDS`: go to ERROR.
    - `len == 0`: go to MARK0.
    - Otherwise: go to DATA.
- **DATA**
  - Even-numbered bytes are latched as the low byte.
  - On each odd-numbered byte, write `{rx_byte, low}` to `hw[wp]`, then `wp++` and `load_bytes += 2`.
  - After the write for byte `len-1`, go to MARK0.
- **MARK0**: write `16'h1111` to `hw[wp]`, `wp++`, go to MARK1.
- **MARK1**: write `16'h0000` to `hw[wp]`, go to RUN. This places the 32-bit end marker `32'h00001111` at byte offset `len`. Halfword alignment is legal.
- **RUN**
  - `run_flag` = 1.
  - `run_done` clears it and returns to IDLE, making the loader ready for a new image.
  - Bytes are ignored.
- **Timeout**
  - A gap counter clears on each accepted byte and increments otherwise in LEN and DATA.
  - When it reaches `TIMEOUT_CYCLES` (if nonzero), go to ERROR.
- **ERROR**: stays until `clear_error`, then returns to IDLE. `clear_error` in any other state has no effect.
- **Reads**
  - `data` always reflects current RAM contents, including during loading.
  - Index arithmetic wraps modulo the RAM depth; `idx+1` at the top halfword wraps to `hw[0]`.

## Timing
- **Reset values**: state IDLE; `run_flag`, `loading`, `load_error` = 0; `load_bytes`, `wp`, gap counter, `len` = 0. RAM contents are not cleared.
- **Write visibility**: a RAM write occurs at the edge that samples the completing byte (or at the MARK edge). It is visible on `data` in the following cycle.
- **Latency**:
  - The last payload byte is sampled at edge E.
  - Marker low half is written at E+1, marker high half at E+2.
  - `run_flag` is high from E+2.
- **Simultaneous events**:
  - `run_done` together with `rx_valid` in RUN: go to IDLE; the byte is dropped.
  - `rx_valid` on the same edge the timeout fires: the byte wins and the counter clears.
  - `reset` overrides everything, including mid-load. A partially written image stays in RAM but `run_flag` stays 0.

## Structure
- Package `common` gets:
  - `loader_state_type` enum (IDLE, LEN, DATA, MARK0, MARK1, RUN, ERROR).
  - `END_MARKER = 32'h00001111`, shared with the fetch stage's end-instruction compare.
- Sub-module `instr_mem`:
  - 16-bit RAM of depth 2*MEM_WORDS.
  - One synchronous write port (`we`, `waddr`, `wdata`).
  - Two combinational read ports (`idx`, `idx+1`).
- Loader FSM, byte assembly, gap counter and length check live in `instr_loader_mem`.

## Test plan
1. **Basic load**
   - Stimulus: send bytes `08 00 00 00 13 05 10 00 93 05 20 00`.
   - Required: `hw[0..3]` = `0513 0010 0593 0020`; `hw[4]=1111`, `hw[5]=0000`; `load_bytes=8`; `run_flag` rises 2 cycles after the last byte.
   - Then `address=4` reads `32'h00200593`.
2. **Halfword-aligned marker**
   - Stimulus: `len=2`, payload `01 45` (c.li).
   - Required: `address=2` reads `32'h00001111`; `address=0` reads `32'h11114501`.
3. **Errors**
   - `len=3`: go to ERROR after the 4th byte; `load_error=1`; following bytes are ignored; `clear_error` returns to IDLE.
   - `len=4*MEM_WORDS`: same ERROR behaviour.
4. **Timeout**
   - Stimulus: `TIMEOUT_CYCLES=16`; stop after 5 bytes.
   - Required: ERROR exactly 16 cycles after the 5th byte. A byte arriving at cycle 15 keeps DATA.
5. **Run/reload**
   - Pulse `run_done` with `rx_valid` in RUN: `run_flag` drops the next cycle and the byte is dropped.
   - A second image then loads correctly from `hw[0]`.
6. **Reset mid-DATA**
   - Stimulus: assert `reset` mid-DATA.
   - Required: all outputs 0 on the next cycle, and a new load from a fresh header succeeds.
